// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that merges FU_COUNT functional-unit result
// channels into one ROB write-back port and one common-data-bus broadcast.
//
// Each channel owns a one-entry holding register. A single output register
// takes one held result per cycle. The scan for the next winner starts at
// rr_ptr. Flush discards every held result and the output register.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready per-channel handshake (in_ready = holding register empty)
//   in_robid/in_wbs/in_flags/in_value/in_cdb  packed per-channel result fields
//   flush             squash all held and presented results
//   out_valid/out_ready  ROB-side handshake
//   out_robid/out_wbs/out_flags/out_value    granted result fields
//   out_cdb_transmit/out_cdb_id/out_cdb_val  CDB broadcast of the granted result
module cdb_arbiter #(
  parameter int FU_COUNT = 8,
  parameter int ROBID_W  = 4,
  parameter int PREG_W   = 4,
  parameter int DATA_W   = 8,
  parameter int FLAG_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FU_COUNT-1:0]            in_valid,
  output logic [FU_COUNT-1:0]            in_ready,
  input  logic [FU_COUNT*ROBID_W-1:0]    in_robid,
  input  logic [FU_COUNT*2*PREG_W-1:0]   in_wbs,
  input  logic [FU_COUNT*FLAG_W-1:0]     in_flags,
  input  logic [FU_COUNT*DATA_W-1:0]     in_value,
  input  logic [FU_COUNT-1:0]            in_cdb,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ROBID_W-1:0]             out_robid,
  output logic [2*PREG_W-1:0]            out_wbs,
  output logic [FLAG_W-1:0]              out_flags,
  output logic [DATA_W-1:0]              out_value,
  output logic                           out_cdb_transmit,
  output logic [PREG_W-1:0]              out_cdb_id,
  output logic [DATA_W-1:0]              out_cdb_val
);

  localparam int IDX_W = $clog2(FU_COUNT);

  logic [FU_COUNT-1:0]  vld_p0;
  logic [ROBID_W-1:0]   robid_p0 [FU_COUNT];
  logic [2*PREG_W-1:0]  wbs_p0   [FU_COUNT];
  logic [FLAG_W-1:0]    flags_p0 [FU_COUNT];
  logic [DATA_W-1:0]    value_p0 [FU_COUNT];
  logic [FU_COUNT-1:0]  cdb_p0;

  logic                 vld_p1;
  logic [ROBID_W-1:0]   robid_p1;
  logic [2*PREG_W-1:0]  wbs_p1;
  logic [FLAG_W-1:0]    flags_p1;
  logic [DATA_W-1:0]    value_p1;
  logic                 cdb_p1;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_next;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_found;
  logic                 load;
  logic [FU_COUNT-1:0]  cap;
  logic [FU_COUNT-1:0]  clr;

  // Ready comes straight from the holding-register state, so it never
  // depends combinationally on any input.
  assign in_ready = ~vld_p0;
  assign cap      = in_valid & ~vld_p0 & {FU_COUNT{~flush}};
  assign load     = gnt_found & (~vld_p1 | out_ready) & ~flush;
  assign clr      = load ? ({{(FU_COUNT-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign rr_next  = (gnt_idx == IDX_W'(FU_COUNT - 1)) ? '0 : gnt_idx + 1'b1;

  // Circular scan from rr_ptr; the wrap is done explicitly so FU_COUNT need
  // not be a power of two.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] cur;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    cur       = '0;
    for (int k = 0; k < FU_COUNT; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= FU_COUNT) pos = pos - FU_COUNT;
      cur = pos[IDX_W-1:0];
      if (!gnt_found && vld_p0[cur]) begin
        gnt_found = 1'b1;
        gnt_idx   = cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else if (flush) begin
      vld_p0 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      // cap only touches empty slots and clr only the full winner, so the
      // granted slot cannot be refilled at its grant edge.
      vld_p0 <= (vld_p0 | cap) & ~clr;
      if (load) begin
        vld_p1 <= 1'b1;
        rr_ptr <= rr_next;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p0: per-channel holding registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_COUNT; i++) begin
      if (cap[i]) begin
        robid_p0[i] <= in_robid[i*ROBID_W +: ROBID_W];
        wbs_p0[i]   <= in_wbs[i*2*PREG_W +: 2*PREG_W];
        flags_p0[i] <= in_flags[i*FLAG_W +: FLAG_W];
        value_p0[i] <= in_value[i*DATA_W +: DATA_W];
        cdb_p0[i]   <= in_cdb[i];
      end
    end
  end

  // Stage p1: output register; its fields read as zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      robid_p1 <= '0;
      wbs_p1   <= '0;
      flags_p1 <= '0;
      value_p1 <= '0;
      cdb_p1   <= 1'b0;
    end else if (load) begin
      robid_p1 <= robid_p0[gnt_idx];
      wbs_p1   <= wbs_p0[gnt_idx];
      flags_p1 <= flags_p0[gnt_idx];
      value_p1 <= value_p0[gnt_idx];
      cdb_p1   <= cdb_p0[gnt_idx];
    end
  end

  assign out_valid        = vld_p1;
  assign out_robid        = robid_p1;
  assign out_wbs          = wbs_p1;
  assign out_flags        = flags_p1;
  assign out_value        = value_p1;
  assign out_cdb_transmit = vld_p1 & cdb_p1;
  assign out_cdb_id       = wbs_p1[PREG_W-1:0];
  assign out_cdb_val      = value_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (default parameters).
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [31:0] in_robid;
  logic [63:0] in_wbs;
  logic [63:0] in_flags;
  logic [63:0] in_value;
  logic [7:0]  in_cdb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_robid;
  logic [7:0]  out_wbs;
  logic [7:0]  out_flags;
  logic [7:0]  out_value;
  logic        out_cdb_transmit;
  logic [3:0]  out_cdb_id;
  logic [7:0]  out_cdb_val;

  typedef struct packed {
    logic [3:0] robid;
    logic [7:0] wbs;
    logic [7:0] flags;
    logic [7:0] value;
    logic       tx;
    logic [3:0] id;
    logic [7:0] val;
  } res_t;

  res_t q[$];
  int   checks   = 0;
  int   failures = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_robid(in_robid), .in_wbs(in_wbs), .in_flags(in_flags),
    .in_value(in_value), .in_cdb(in_cdb), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_robid(out_robid), .out_wbs(out_wbs), .out_flags(out_flags),
    .out_value(out_value), .out_cdb_transmit(out_cdb_transmit),
    .out_cdb_id(out_cdb_id), .out_cdb_val(out_cdb_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present one result on channel ch; optionally record it as expected output.
  task automatic put(input int ch, input logic [3:0] r, input logic [7:0] w,
                     input logic [7:0] f, input logic [7:0] v, input logic c,
                     input bit push);
    res_t e;
    in_valid[ch]       = 1'b1;
    in_robid[ch*4 +: 4] = r;
    in_wbs[ch*8 +: 8]   = w;
    in_flags[ch*8 +: 8] = f;
    in_value[ch*8 +: 8] = v;
    in_cdb[ch]         = c;
    if (push) begin
      e.robid = r; e.wbs = w; e.flags = f; e.value = v;
      e.tx = c; e.id = w[3:0]; e.val = v;
      q.push_back(e);
    end
  endtask

  // Monitor: every accepted output is popped and compared.
  always @(negedge clk) begin
    res_t got;
    res_t e;
    if (!rst && out_valid && out_ready) begin
      got = {out_robid, out_wbs, out_flags, out_value,
             out_cdb_transmit, out_cdb_id, out_cdb_val};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got=%h exp=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sb_result got=%h exp=%h", got, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_robid = '0; in_wbs = '0; in_flags = '0;
    in_value = '0; in_cdb = '0;
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 8'hFF);
    chk("rst_out_robid", out_robid, 0);
    chk("rst_cdb_tx", out_cdb_transmit, 0);
    rst = 1'b0;

    // all eight channels at once: ch0..ch7 on consecutive cycles
    for (int i = 0; i < 8; i++)
      put(i, 4'(i), {4'(i), 4'(15 - i)}, 8'(i * 3), 8'h10 + 8'(i), i[0], 1);
    step();
    in_valid = '0;
    chk("rr_in_ready_low", in_ready, 8'h00);
    chk("rr_no_out_yet", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_valid", out_valid, 1);
      chk("rr_order", out_robid, 4'(k));
    end
    step();
    chk("rr_drain", out_valid, 0);

    // ch0 + ch7 after wrap: ch0 first
    put(0, 4'hA, 8'h1A, 8'h00, 8'h55, 1'b1, 1);
    put(7, 4'hB, 8'h2B, 8'h01, 8'h66, 1'b0, 1);
    step();
    in_valid = '0;
    step();
    chk("pair_first", out_robid, 4'hA);
    step();
    chk("pair_second", out_robid, 4'hB);
    step();
    chk("pair_drain", out_valid, 0);

    // single result on ch3, two-cycle latency
    put(3, 4'd5, 8'h29, 8'h11, 8'hA5, 1'b1, 1);
    step();
    in_valid = '0;
    chk("single_ready_low", in_ready[3], 0);
    chk("single_not_yet", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_robid", out_robid, 4'd5);
    chk("single_tx", out_cdb_transmit, 1);
    chk("single_cdb_id", out_cdb_id, 4'h9);
    chk("single_cdb_val", out_cdb_val, 8'hA5);
    chk("single_ready_back", in_ready[3], 1);
    step();
    chk("single_drain", out_valid, 0);

    // non-CDB result on ch2
    put(2, 4'h6, 8'h71, 8'h00, 8'h3C, 1'b0, 1);
    step();
    in_valid = '0;
    step();
    chk("nocdb_valid", out_valid, 1);
    chk("nocdb_tx", out_cdb_transmit, 0);
    step();

    // backpressure: rr_ptr=3, so order is ch4, ch6, ch1
    out_ready = 1'b0;
    put(4, 4'd4, 8'h44, 8'h04, 8'hC4, 1'b1, 1);
    put(6, 4'd6, 8'h66, 8'h06, 8'hC6, 1'b0, 1);
    put(1, 4'd1, 8'h11, 8'h01, 8'hC1, 1'b1, 1);
    step();
    in_valid = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_robid", out_robid, 4'd4);
      chk("bp_value", out_value, 8'hC4);
      chk("bp_ready_low", in_ready & 8'h42, 8'h00);
      step();
    end
    out_ready = 1'b1;
    chk("bp_r0", out_robid, 4'd4);
    step();
    chk("bp_v1", out_valid, 1);
    chk("bp_r1", out_robid, 4'd6);
    step();
    chk("bp_v2", out_valid, 1);
    chk("bp_r2", out_robid, 4'd1);
    step();
    chk("bp_drain", out_valid, 0);

    // flush: rr_ptr=2, ch2 reaches the output, 0/3/5/7 stay pending
    out_ready = 1'b0;
    put(0, 4'd0, 8'h00, 8'h00, 8'hD0, 1'b1, 0);
    put(2, 4'd2, 8'h22, 8'h00, 8'hD2, 1'b1, 0);
    put(3, 4'd3, 8'h33, 8'h00, 8'hD3, 1'b1, 0);
    put(5, 4'd5, 8'h55, 8'h00, 8'hD5, 1'b1, 0);
    put(7, 4'd7, 8'h77, 8'h00, 8'hD7, 1'b1, 0);
    step();
    in_valid = '0;
    step();
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_robid", out_robid, 4'd2);
    chk("fl_pre_ready", in_ready, 8'h56);
    flush = 1'b1;
    put(1, 4'd1, 8'h11, 8'h00, 8'hD1, 1'b1, 0);
    step();
    flush = 1'b0;
    in_valid = '0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 8'hFF);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_quiet", out_valid, 0);
    end

    // reset mid-operation: rr_ptr=3 before reset
    out_ready = 1'b0;
    put(1, 4'd1, 8'h11, 8'h01, 8'hE1, 1'b1, 0);
    put(4, 4'd4, 8'h44, 8'h04, 8'hE4, 1'b1, 0);
    step();
    in_valid = '0;
    step();
    chk("rm_pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", out_valid, 0);
    chk("rm_robid", out_robid, 0);
    chk("rm_wbs", out_wbs, 0);
    chk("rm_value", out_value, 0);
    chk("rm_tx", out_cdb_transmit, 0);
    chk("rm_ready", in_ready, 8'hFF);
    out_ready = 1'b1;
    put(2, 4'h8, 8'h3D, 8'h20, 8'h92, 1'b1, 1);
    put(6, 4'h9, 8'h4E, 8'h60, 8'h96, 1'b1, 1);
    step();
    in_valid = '0;
    step();
    chk("rm_scan0_first", out_robid, 4'h8);
    step();
    chk("rm_scan0_second", out_robid, 4'h9);
    step();
    chk("rm_drain", out_valid, 0);

    repeat (2) step();
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
